// File: rtl/sigmf_arb.sv
// sigmf_arb: round-robin arbiter feeding one shared combinational sigmoid unit, two register stages.
// Defining SIGMF_ARB_STATS_EN adds per-requester saturating accept counters (stat_sel/stat_clr/stat_cnt).
module sigmf_arb #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 3,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*WIDTH-1:0]   req_data,
  output logic [NREQ-1:0]         req_ready,
  output logic signed [WIDTH-1:0] sig_in,
  input  logic signed [WIDTH-1:0] sig_out,
  output logic                    resp_valid,
  output logic signed [WIDTH-1:0] resp_data,
  output logic [IDW-1:0]          resp_id,
  input  logic                    resp_ready
`ifdef SIGMF_ARB_STATS_EN
  ,
  input  logic [IDW-1:0]          stat_sel,
  input  logic                    stat_clr,
  output logic [15:0]             stat_cnt
`endif
);

  logic                    vld_p0_q, vld_p0_d;
  logic signed [WIDTH-1:0] data_p0_q, data_p0_d;
  logic [IDW-1:0]          id_p0_q, id_p0_d;
  logic                    vld_p1_q, vld_p1_d;
  logic signed [WIDTH-1:0] data_p1_q, data_p1_d;
  logic [IDW-1:0]          id_p1_q, id_p1_d;
  logic [IDW-1:0]          rr_ptr_q, rr_ptr_d;

  logic                    b_load, a_load, accept;
  logic                    hi_vld, lo_vld, gnt_vld;
  logic [IDW-1:0]          hi_id, lo_id, gnt_id;
  logic signed [WIDTH-1:0] gnt_data;

  function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] k);
    return (k == IDW'(NREQ - 1)) ? '0 : k + IDW'(1);
  endfunction

  // Round-robin search: lowest valid index at or above rr_ptr, else lowest valid index overall.
  always_comb begin
    hi_vld = 1'b0;
    lo_vld = 1'b0;
    hi_id  = '0;
    lo_id  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_valid[k]) begin
        lo_vld = 1'b1;
        lo_id  = IDW'(k);
        if (IDW'(k) >= rr_ptr_q) begin
          hi_vld = 1'b1;
          hi_id  = IDW'(k);
        end
      end
    end
    gnt_vld  = lo_vld;
    gnt_id   = hi_vld ? hi_id : lo_id;
    gnt_data = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (gnt_id == IDW'(k)) gnt_data = req_data[k*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    b_load    = !vld_p1_q || resp_ready;
    a_load    = !vld_p0_q || b_load;
    accept    = a_load && gnt_vld;
    req_ready = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (accept && rst_n && gnt_id == IDW'(k)) req_ready[k] = 1'b1;
    end
    rr_ptr_d  = accept ? wrap_inc(gnt_id) : rr_ptr_q;
    // p0: operand register in front of the shared sigmoid unit
    vld_p0_d  = a_load ? accept : vld_p0_q;
    data_p0_d = accept ? gnt_data : data_p0_q;
    id_p0_d   = accept ? gnt_id : id_p0_q;
    // p1: result register capturing sig_out
    vld_p1_d  = b_load ? vld_p0_q : vld_p1_q;
    data_p1_d = (b_load && vld_p0_q) ? sig_out : data_p1_q;
    id_p1_d   = (b_load && vld_p0_q) ? id_p0_q : id_p1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0_q  <= 1'b0;
      data_p0_q <= '0;
      id_p0_q   <= '0;
      vld_p1_q  <= 1'b0;
      data_p1_q <= '0;
      id_p1_q   <= '0;
      rr_ptr_q  <= '0;
    end else begin
      vld_p0_q  <= vld_p0_d;
      data_p0_q <= data_p0_d;
      id_p0_q   <= id_p0_d;
      vld_p1_q  <= vld_p1_d;
      data_p1_q <= data_p1_d;
      id_p1_q   <= id_p1_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

  assign sig_in     = data_p0_q;
  assign resp_valid = vld_p1_q;
  assign resp_data  = data_p1_q;
  assign resp_id    = id_p1_q;

`ifdef SIGMF_ARB_STATS_EN
  logic [15:0] cnt_q [NREQ];
  logic [15:0] cnt_d [NREQ];

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  // Clear takes priority over a same-cycle accept.
  always_comb begin
    stat_cnt = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (stat_clr)                         cnt_d[k] = '0;
      else if (accept && gnt_id == IDW'(k)) cnt_d[k] = sat_inc(cnt_q[k]);
      else                                  cnt_d[k] = cnt_q[k];
      if (stat_sel == IDW'(k)) stat_cnt = cnt_q[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NREQ; k++) cnt_q[k] <= '0;
    end else begin
      for (int k = 0; k < NREQ; k++) cnt_q[k] <= cnt_d[k];
    end
  end
`endif

endmodule

// File: tb/tb_sigmf_arb.sv
// Directed bench for sigmf_arb with a hard-sigmoid stand-in (clamp(0.5 + x/4, 0, 1) in Q8.24).
module tb_sigmf_arb;
  localparam int WIDTH = 32;
  localparam int NREQ  = 3;
  localparam int IDW   = 2;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [NREQ-1:0]         req_valid, req_ready;
  logic [NREQ*WIDTH-1:0]   req_data;
  logic signed [WIDTH-1:0] sig_in, sig_out, resp_data, sig_t;
  logic                    resp_valid, resp_ready;
  logic [IDW-1:0]          resp_id;
`ifdef SIGMF_ARB_STATS_EN
  logic [IDW-1:0]          stat_sel;
  logic                    stat_clr;
  logic [15:0]             stat_cnt;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] ops [9] = '{32'h01000000, 32'hFF000000, 32'h04000000, 32'hF8000000, 32'h00400000,
                           32'h02000000, 32'hFE000000, 32'h00000004, 32'hFFFFFFFC};
  logic [31:0] exps [9] = '{32'h00C00000, 32'h00400000, 32'h01000000, 32'h00000000, 32'h00900000,
                            32'h01000000, 32'h00000000, 32'h00800001, 32'h007FFFFF};

  always #5 clk = ~clk;

  always_comb begin
    sig_t = (sig_in >>> 2) + 32'sh00800000;
    if (sig_t < 0)                    sig_out = '0;
    else if (sig_t > 32'sh01000000)   sig_out = 32'sh01000000;
    else                              sig_out = sig_t;
  end

  sigmf_arb #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .sig_in(sig_in), .sig_out(sig_out), .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_id(resp_id), .resp_ready(resp_ready)
`ifdef SIGMF_ARB_STATS_EN
    , .stat_sel(stat_sel), .stat_clr(stat_clr), .stat_cnt(stat_cnt)
`endif
  );

  task automatic set_op(input int k, input logic [31:0] v);
    req_data[k*WIDTH +: WIDTH] = v;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 3'b111; req_data = '0; resp_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid: got %b want 0", resp_valid); end
    checks++; if (resp_data !== 32'h0) begin errors++; $display("FAIL rst_resp_data: got %h want 0", resp_data); end
    checks++; if (resp_id !== 2'd0) begin errors++; $display("FAIL rst_resp_id: got %0d want 0", resp_id); end
    checks++; if (sig_in !== 32'h0) begin errors++; $display("FAIL rst_sig_in: got %h want 0", sig_in); end
    checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL rst_req_ready: got %b want 000", req_ready); end
    // fill both stages under backpressure, then reset asynchronously
    @(negedge clk); rst_n = 1'b1; req_valid = 3'b001; set_op(0, 32'h01000000); resp_ready = 1'b0;
    #1;
    checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL rel_first_grant: got %b want 001", req_ready); end
    repeat (2) @(negedge clk);
    #1;
    checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL full_resp_valid: got %b want 1", resp_valid); end
    checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL full_req_ready: got %b want 000", req_ready); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL async_resp_valid: got %b want 0", resp_valid); end
    checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL async_req_ready: got %b want 000", req_ready); end
    checks++; if (sig_in !== 32'h0) begin errors++; $display("FAIL async_sig_in: got %h want 0", sig_in); end
    @(negedge clk);
    rst_n = 1'b1; req_valid = 3'b011; set_op(0, 32'h01000000); set_op(1, 32'hFF000000); resp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL rst_ptr_grant: got %b want 001", req_ready); end
    @(negedge clk); req_valid = 3'b010;
    #1;
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL lat_early: got %b want 0", resp_valid); end
    checks++; if (sig_in !== 32'h01000000) begin errors++; $display("FAIL lat_sig_in: got %h want 01000000", sig_in); end
    @(negedge clk); req_valid = 3'b000;
    #1;
    checks++; if (resp_valid !== 1'b1 || resp_id !== 2'd0 || resp_data !== 32'h00C00000) begin
      errors++; $display("FAIL lat_resp0: got v=%b id=%0d d=%h want v=1 id=0 d=00c00000", resp_valid, resp_id, resp_data);
    end
    @(negedge clk); #1;
    checks++; if (resp_valid !== 1'b1 || resp_id !== 2'd1 || resp_data !== 32'h00400000) begin
      errors++; $display("FAIL lat_resp1: got v=%b id=%0d d=%h want v=1 id=1 d=00400000", resp_valid, resp_id, resp_data);
    end
    @(negedge clk); #1;
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL lat_drain: got %b want 0", resp_valid); end
  endtask

  task automatic test_single();
    @(negedge clk); req_valid = 3'b010; set_op(1, 32'h0); resp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 3'b010) begin errors++; $display("FAIL single_ready: got %b want 010", req_ready); end
    @(negedge clk); req_valid = 3'b000;
    #1;
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL single_early: got %b want 0", resp_valid); end
    @(negedge clk); #1;
    checks++; if (resp_valid !== 1'b1 || resp_id !== 2'd1 || resp_data !== 32'h00800000) begin
      errors++; $display("FAIL single_resp: got v=%b id=%0d d=%h want v=1 id=1 d=00800000", resp_valid, resp_id, resp_data);
    end
    @(negedge clk); #1;
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL single_dup: got %b want 0", resp_valid); end
  endtask

  task automatic test_pointer_wrap();
    @(negedge clk); req_valid = 3'b011; set_op(0, 32'h01000000); set_op(1, 32'h02000000);
    #1;
    checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL wrap_grant0: got %b want 001", req_ready); end
    @(negedge clk); req_valid = 3'b010;
    #1;
    checks++; if (req_ready !== 3'b010) begin errors++; $display("FAIL wrap_grant1: got %b want 010", req_ready); end
    @(negedge clk); req_valid = 3'b000;
    #1;
    checks++; if (resp_valid !== 1'b1 || resp_id !== 2'd0 || resp_data !== 32'h00C00000) begin
      errors++; $display("FAIL wrap_resp0: got v=%b id=%0d d=%h want v=1 id=0 d=00c00000", resp_valid, resp_id, resp_data);
    end
    @(negedge clk); #1;
    checks++; if (resp_valid !== 1'b1 || resp_id !== 2'd1 || resp_data !== 32'h01000000) begin
      errors++; $display("FAIL wrap_resp1: got v=%b id=%0d d=%h want v=1 id=1 d=01000000", resp_valid, resp_id, resp_data);
    end
    @(negedge clk); #1;
  endtask

  task automatic test_contention();
    logic [2:0] exp_rdy;
    rst_n = 1'b0; req_valid = '0; resp_ready = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i <= 11; i++) begin
      for (int k = 0; k < 3; k++) begin
        int j;
        j = (i + 2 - k) / 3;
        req_valid[k] = (j < 3);
        set_op(k, (j < 3) ? ops[3*j + k] : 32'h0);
      end
      #1;
      if (i < 9) begin
        exp_rdy = 3'b001 << (i % 3);
        checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL cont_ready[%0d]: got %b want %b", i, req_ready, exp_rdy); end
      end
      if (i >= 2 && i <= 10) begin
        checks++;
        if (resp_valid !== 1'b1 || resp_id !== IDW'((i - 2) % 3) || resp_data !== exps[i-2]) begin
          errors++;
          $display("FAIL cont_resp[%0d]: got v=%b id=%0d d=%h want v=1 id=%0d d=%h",
                   i - 2, resp_valid, resp_id, resp_data, (i - 2) % 3, exps[i-2]);
        end
      end
      if (i == 11) begin
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL cont_drain: got %b want 0", resp_valid); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    logic [2:0] rv [8] = '{3'b101, 3'b101, 3'b001, 3'b001, 3'b001, 3'b000, 3'b000, 3'b000};
    logic       rr [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [2:0] er [8] = '{3'b001, 3'b100, 3'b000, 3'b000, 3'b001, 3'b000, 3'b000, 3'b000};
    int accepts = 0;
    for (int i = 0; i < 8; i++) begin
      req_valid = rv[i]; resp_ready = rr[i];
      set_op(0, (i == 0) ? 32'h01000000 : 32'h00400000);
      set_op(2, 32'hFF000000);
      #1;
      checks++; if (req_ready !== er[i]) begin errors++; $display("FAIL bp_ready[%0d]: got %b want %b", i, req_ready, er[i]); end
      if (i < 4) accepts += $countones(req_valid & req_ready);
      if (i == 1 || i == 7) begin
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL bp_idle[%0d]: got %b want 0", i, resp_valid); end
      end
      if (i >= 2 && i <= 4) begin
        checks++; if (resp_valid !== 1'b1 || resp_id !== 2'd0 || resp_data !== 32'h00C00000) begin
          errors++; $display("FAIL bp_hold[%0d]: got v=%b id=%0d d=%h want v=1 id=0 d=00c00000", i, resp_valid, resp_id, resp_data);
        end
      end
      if (i == 5) begin
        checks++; if (resp_valid !== 1'b1 || resp_id !== 2'd2 || resp_data !== 32'h00400000) begin
          errors++; $display("FAIL bp_drain2: got v=%b id=%0d d=%h want v=1 id=2 d=00400000", resp_valid, resp_id, resp_data);
        end
      end
      if (i == 6) begin
        checks++; if (resp_valid !== 1'b1 || resp_id !== 2'd0 || resp_data !== 32'h00900000) begin
          errors++; $display("FAIL bp_drain0: got v=%b id=%0d d=%h want v=1 id=0 d=00900000", resp_valid, resp_id, resp_data);
        end
      end
      if (i == 3) begin
        checks++; if (accepts != 2) begin errors++; $display("FAIL bp_accepts: got %0d want 2", accepts); end
      end
      @(negedge clk);
    end
  endtask

`ifdef SIGMF_ARB_STATS_EN
  task automatic test_stats();
    stat_clr = 1'b0;
    stat_sel = 2'd0; #1;
    checks++; if (stat_cnt !== 16'd5) begin errors++; $display("FAIL stat_cnt0: got %0d want 5", stat_cnt); end
    stat_sel = 2'd1; #1;
    checks++; if (stat_cnt !== 16'd3) begin errors++; $display("FAIL stat_cnt1: got %0d want 3", stat_cnt); end
    stat_sel = 2'd2; #1;
    checks++; if (stat_cnt !== 16'd4) begin errors++; $display("FAIL stat_cnt2: got %0d want 4", stat_cnt); end
    @(negedge clk); req_valid = 3'b100; set_op(2, 32'h0); resp_ready = 1'b1;
    repeat (70000) @(negedge clk);
    #1;
    checks++; if (stat_cnt !== 16'hFFFF) begin errors++; $display("FAIL stat_sat: got %h want ffff", stat_cnt); end
    stat_clr = 1'b1;
    @(negedge clk); stat_clr = 1'b0;
    #1;
    checks++; if (stat_cnt !== 16'd0) begin errors++; $display("FAIL stat_clr: got %0d want 0", stat_cnt); end
    @(negedge clk); req_valid = 3'b000;
    #1;
    checks++; if (stat_cnt !== 16'd1) begin errors++; $display("FAIL stat_after_clr: got %0d want 1", stat_cnt); end
    repeat (3) @(negedge clk);
  endtask
`endif

  initial begin
`ifdef SIGMF_ARB_STATS_EN
    stat_sel = '0;
    stat_clr = 1'b0;
`endif
    test_reset();
    test_single();
    test_pointer_wrap();
    test_contention();
    test_backpressure();
`ifdef SIGMF_ARB_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
